relu_stream_ctrl: RTL and testbench

Sequencer that streams one 26x26 convolution feature map (676 signed 20-bit values) out of the conv result buffer, applies ReLU across a small number of parallel lanes, and writes the results into the pooling input buffer. It replaces the fully parallel 676-wide ReLU stage with a time-multiplexed datapath. It sits between the conv layer's result RAM and the max-pool stage, and is started once per feature map by the layer controller.

---
 rtl/relu_stream_ctrl_if.sv | 43 ++++
 rtl/relu_stream_ctrl.sv | 169 ++++++++++++++++
 tb/tb_relu_stream_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/relu_stream_ctrl_if.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : relu_stream_ctrl_if
// Description : Bundle of the start/control inputs, conv-result RAM read port,
//               pool-buffer write port and status outputs of relu_stream_ctrl.
//               slave  : the sequencer itself
//               master : layer controller / RAM / pool buffer side
// Ports       : start, relu_en, hold     control from the layer controller
//               rd_en, rd_addr, rd_data  read port of the conv result RAM
//               wr_en, wr_addr, wr_data  write port of the pool input buffer
//               busy, done, neg_count    status back to the layer controller
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
interface relu_stream_ctrl_if #(
    parameter int LANES = 4,
    parameter int DW    = 20,
    parameter int AW    = 8,
    parameter int NW    = 10
);
    logic                  start;
    logic                  relu_en;
    logic                  hold;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [LANES*DW-1:0]   rd_data;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [LANES*DW-1:0]   wr_data;
    logic                  busy;
    logic                  done;
    logic [NW-1:0]         neg_count;

    modport slave (
        input  start, relu_en, hold, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, neg_count
    );

    modport master (
        output start, relu_en, hold, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, neg_count
    );
endinterface
`default_nettype wire

// File: rtl/relu_stream_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : relu_stream_ctrl
// Description : Streams one feature map out of the conv result RAM, LANES
//               elements per cycle, applies an optional ReLU per lane, writes
//               the chunks into the pool input buffer and counts negative
//               input elements.
// Ports       : clk  - sole clock, rising edge
//               rst  - synchronous, active-low reset
//               bus  - relu_stream_ctrl_if.slave (control, RAM read port,
//                      pool write port, busy/done/neg_count status)
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module relu_stream_ctrl #(
    parameter int N_ELEM = 676,
    parameter int LANES  = 4,
    parameter int DW     = 20
) (
    input  wire logic          clk,
    input  wire logic          rst,
    relu_stream_ctrl_if.slave  bus
);

    localparam int c_N_CHUNK = N_ELEM / LANES;
    localparam int c_AW      = $clog2(c_N_CHUNK);
    localparam int c_NW      = $clog2(N_ELEM + 1);
    localparam int c_W       = LANES * DW;
    localparam logic [c_AW-1:0] c_LAST = c_AW'(c_N_CHUNK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state_q,     w_state_d;
    logic                r_relu_en_q,   w_relu_en_d;
    logic [c_AW-1:0]     r_cnt_q,       w_cnt_d;
    logic                r_rd_en_q,     w_rd_en_d;
    logic [c_AW-1:0]     r_rd_addr_q,   w_rd_addr_d;
    logic                r_vld_q,       w_vld_d;
    logic [c_AW-1:0]     r_vaddr_q,     w_vaddr_d;
    logic                r_wr_en_q,     w_wr_en_d;
    logic [c_AW-1:0]     r_wr_addr_q,   w_wr_addr_d;
    logic [c_W-1:0]      r_wr_data_q,   w_wr_data_d;
    logic                r_busy_q,      w_busy_d;
    logic                r_done_q,      w_done_d;
    logic [c_NW-1:0]     r_neg_q,       w_neg_d;

    logic [c_W-1:0]      w_relu;
    logic [c_NW-1:0]     w_neg_lanes;

    // Per-lane ReLU and negative-lane count of the data returned by the RAM.
    always_comb begin
        w_relu      = '0;
        w_neg_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            if (bus.rd_data[k*DW + DW - 1]) begin
                w_neg_lanes = w_neg_lanes + c_NW'(1);
            end
            if (r_relu_en_q && bus.rd_data[k*DW + DW - 1]) begin
                w_relu[k*DW +: DW] = '0;
            end else begin
                w_relu[k*DW +: DW] = bus.rd_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_relu_en_d = r_relu_en_q;
        w_cnt_d     = r_cnt_q;
        w_rd_en_d   = 1'b0;
        w_rd_addr_d = r_rd_addr_q;
        // RAM data is valid the cycle after the strobe; the write for it is
        // registered one cycle later still.
        w_vld_d     = r_rd_en_q;
        w_vaddr_d   = r_rd_addr_q;
        w_wr_en_d   = r_vld_q;
        w_wr_addr_d = r_vld_q ? r_vaddr_q : r_wr_addr_q;
        w_wr_data_d = r_vld_q ? w_relu    : r_wr_data_q;
        w_neg_d     = r_neg_q + (r_vld_q ? w_neg_lanes : '0);

        case (r_state_q)
            IDLE: begin
                if (bus.start) begin
                    // Chunk 0 is issued on the accepting edge so the first
                    // strobe lands in the cycle right after start; the
                    // counter therefore restarts at 1.
                    w_state_d   = RUN;
                    w_relu_en_d = bus.relu_en;
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = '0;
                    w_cnt_d     = c_AW'(1);
                    w_neg_d     = '0;
                end
            end
            RUN: begin
                if (!bus.hold) begin
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = r_cnt_q;
                    w_cnt_d     = r_cnt_q + c_AW'(1);
                    if (r_cnt_q == c_LAST) begin
                        w_state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (r_wr_en_q && (r_wr_addr_q == c_LAST)) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Status flags follow the next state so they line up with it.
        w_busy_d = (w_state_d != IDLE);
        w_done_d = (w_state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q   <= IDLE;
            r_relu_en_q <= 1'b0;
            r_cnt_q     <= '0;
            r_rd_en_q   <= 1'b0;
            r_rd_addr_q <= '0;
            r_vld_q     <= 1'b0;
            r_vaddr_q   <= '0;
            r_wr_en_q   <= 1'b0;
            r_wr_addr_q <= '0;
            r_wr_data_q <= '0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_neg_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_relu_en_q <= w_relu_en_d;
            r_cnt_q     <= w_cnt_d;
            r_rd_en_q   <= w_rd_en_d;
            r_rd_addr_q <= w_rd_addr_d;
            r_vld_q     <= w_vld_d;
            r_vaddr_q   <= w_vaddr_d;
            r_wr_en_q   <= w_wr_en_d;
            r_wr_addr_q <= w_wr_addr_d;
            r_wr_data_q <= w_wr_data_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_neg_q     <= w_neg_d;
        end
    end

    assign bus.rd_en     = r_rd_en_q;
    assign bus.rd_addr   = r_rd_addr_q;
    assign bus.wr_en     = r_wr_en_q;
    assign bus.wr_addr   = r_wr_addr_q;
    assign bus.wr_data   = r_wr_data_q;
    assign bus.busy      = r_busy_q;
    assign bus.done      = r_done_q;
    assign bus.neg_count = r_neg_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_stream_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : tb_relu_stream_ctrl
// Description : Self-checking bench for relu_stream_ctrl. A RAM model feeds
//               the read port; a reference model derives the expected read,
//               write and done cycles, the write data and the negative count
//               from the map contents and the hold pattern.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_relu_stream_ctrl;
    localparam int N_ELEM  = 676;
    localparam int LANES   = 4;
    localparam int DW      = 20;
    localparam int N_CHUNK = N_ELEM / LANES;
    localparam int AW      = 8;
    localparam int NW      = 10;
    localparam int W       = LANES * DW;
    localparam int MAXC    = 700;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    relu_stream_ctrl_if #(.LANES(LANES), .DW(DW), .AW(AW), .NW(NW)) bus ();

    relu_stream_ctrl #(.N_ELEM(N_ELEM), .LANES(LANES), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] mem [N_CHUNK];
    bit           hold_at  [MAXC];
    bit           start_at [MAXC];
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom, $urandom, $urandom});
    endfunction

    // RAM model: one-cycle read latency, garbage when not strobed.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
        else           bus.rd_data <= rnd_word();
    end

    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] d, input bit en);
        logic [W-1:0]         o;
        logic signed [DW-1:0] v;
        o = '0;
        for (int k = 0; k < LANES; k++) begin
            v = d[k*DW +: DW];
            o[k*DW +: DW] = (en && v < 0) ? '0 : v;
        end
        return o;
    endfunction

    function automatic int neg_ref(input logic [W-1:0] d);
        logic signed [DW-1:0] v;
        int n;
        n = 0;
        for (int k = 0; k < LANES; k++) begin
            v = d[k*DW +: DW];
            if (v < 0) n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".rd_en"},     W'(bus.rd_en),     '0);
        chk({tag, ".rd_addr"},   W'(bus.rd_addr),   '0);
        chk({tag, ".wr_en"},     W'(bus.wr_en),     '0);
        chk({tag, ".wr_addr"},   W'(bus.wr_addr),   '0);
        chk({tag, ".wr_data"},   bus.wr_data,       '0);
        chk({tag, ".busy"},      W'(bus.busy),      '0);
        chk({tag, ".done"},      W'(bus.done),      '0);
        chk({tag, ".neg_count"}, W'(bus.neg_count), '0);
    endtask

    task automatic fill(input int pat);
        for (int c = 0; c < N_CHUNK; c++) begin
            case (pat)
                0:       mem[c] = {DW'(-1), DW'(5), DW'(-c), DW'(c)};
                1:       mem[c] = {20'hFFFFF, 20'h00000, 20'h80000, 20'h7FFFF};
                default: mem[c] = rnd_word();
            endcase
        end
    endtask

    task automatic clear_patterns();
        for (int i = 0; i < MAXC; i++) begin
            hold_at[i]  = 1'b0;
            start_at[i] = 1'b0;
        end
    endtask

    // Runs one map; cycle 0 is the cycle whose closing edge samples start.
    task automatic run_map(input bit en);
        bit           exp_rd [MAXC];
        bit           exp_wr [MAXC];
        logic [W-1:0] exp_data [N_CHUNK];
        int           e, last_rd, exp_done, exp_neg, rd_i, n_wr;

        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 1'b0;
            exp_wr[i] = 1'b0;
        end
        exp_neg = 0;
        for (int c = 0; c < N_CHUNK; c++) begin
            exp_data[c] = relu_ref(mem[c], en);
            exp_neg    += neg_ref(mem[c]);
        end
        // Read 0 follows the start edge; each later read follows the next
        // edge that sees hold low. Writes trail reads by two cycles.
        last_rd = 1;
        exp_rd[1] = 1'b1;
        e = 1;
        for (int j = 1; j < N_CHUNK; j++) begin
            while (hold_at[e]) e++;
            last_rd = e + 1;
            exp_rd[last_rd] = 1'b1;
            e++;
        end
        for (int i = 0; i < MAXC - 2; i++) if (exp_rd[i]) exp_wr[i+2] = 1'b1;
        exp_done = last_rd + 3;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.relu_en = en;
        bus.hold    = hold_at[0];
        rd_i = 0;
        n_wr = 0;
        for (int k = 1; k <= exp_done + 3; k++) begin
            @(negedge clk);
            bus.start   = start_at[k];
            bus.hold    = hold_at[k];
            bus.relu_en = 1'($urandom);
            chk("rd_en", W'(bus.rd_en), W'(exp_rd[k]));
            if (exp_rd[k] && rd_i < N_CHUNK) begin
                chk("rd_addr", W'(bus.rd_addr), W'(rd_i));
                rd_i++;
            end
            chk("wr_en", W'(bus.wr_en), W'(exp_wr[k]));
            if (bus.wr_en) begin
                if (n_wr < N_CHUNK) begin
                    chk("wr_addr", W'(bus.wr_addr), W'(n_wr));
                    chk("wr_data", bus.wr_data, exp_data[n_wr]);
                end
                n_wr++;
            end
            chk("done", W'(bus.done), W'(k == exp_done));
            chk("busy", W'(bus.busy), W'(k <= exp_done));
            if (k >= exp_done) chk("neg_count", W'(bus.neg_count), W'(exp_neg));
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        chk("n_writes", W'(n_wr), W'(N_CHUNK));
        clear_patterns();
    endtask

    task automatic run_reset_abort();
        fill(2);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.relu_en = 1'b1;
        for (int k = 1; k <= 95; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst = !(k == 80 || k == 81);
            if (k == 81 || k == 82) chk_idle_outputs("mid_reset");
            if (k >= 81) begin
                chk("abort.wr_en", W'(bus.wr_en), '0);
                chk("abort.rd_en", W'(bus.rd_en), '0);
                chk("abort.busy",  W'(bus.busy),  '0);
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.relu_en = 1'b0;
        bus.hold    = 1'b0;
        clear_patterns();
        fill(0);

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic map with ReLU, then bypass on the same data.
        fill(0);
        run_map(1'b1);
        run_map(1'b0);

        // Extreme lane values.
        fill(1);
        run_map(1'b1);

        // Hold for cycles 10..14 and 169.
        fill(0);
        for (int i = 10; i <= 14; i++) hold_at[i] = 1'b1;
        hold_at[169] = 1'b1;
        run_map(1'b1);

        // start while busy and in the done cycle.
        fill(2);
        start_at[50]  = 1'b1;
        start_at[172] = 1'b1;
        run_map(1'b1);

        // Reset mid-run, then a fresh full map.
        run_reset_abort();
        fill(2);
        run_map(1'b1);

        // Random maps with random hold and ignored starts.
        for (int t = 0; t < 3; t++) begin
            fill(2);
            for (int i = 0; i < MAXC / 2; i++) hold_at[i] = ($urandom_range(0, 3) == 0);
            for (int i = 1; i <= 172; i++) start_at[i] = ($urandom_range(0, 15) == 0);
            run_map(1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
